seq_detector_prog: RTL and testbench

- Runtime-programmable serial pattern detector; successor to the fixed 4-bit "1010" detector.
- Pattern bits and length are loaded at run time, up to MAX_LEN bits.
- Supports overlapping and non-overlapping match modes, a valid-qualified input stream, and a saturating match counter.
- Sits on a serial bit stream in front of framing/sync logic; dout is the per-match pulse, match_count feeds status registers.

---
 rtl/seq_det_pkg.sv | 15 +
 rtl/seq_detector_prog_sat_counter.sv | 26 ++
 rtl/seq_detector_prog.sv | 101 ++++++++++
 tb/tb_seq_detector_prog.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_det_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int unsigned MIN_LEN = 2;

  function automatic bit len_legal(input int unsigned len, input int unsigned max);
    return (len >= MIN_LEN) && (len <= max);
  endfunction

endpackage

// File: rtl/seq_detector_prog_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != {W{1'b1}})) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with overlap control,
// valid-qualified input and a saturating match counter.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 16,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               din_valid,
  input  logic               din,
  input  logic               clr_count,
  output logic               dout,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err,
  output logic               armed
);

  state_t             r_state;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic               r_dout;
  logic               r_cfg_err;
  logic               r_armed;

  logic [MAX_LEN-1:0] w_hist_next;
  logic [LEN_W-1:0]   w_fill_next;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_cfg_ok;
  logic               w_match;

  assign w_hist_next = {r_hist[MAX_LEN-2:0], din};
  assign w_fill_next = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
  // A full-width shift yields zero, so len == MAX_LEN still gives an all-ones mask.
  assign w_mask      = ~({MAX_LEN{1'b1}} << r_len);
  assign w_cfg_ok    = len_legal(32'(cfg_len), MAX_LEN);

  // A load in the same cycle drops the incoming bit, so it can never complete a match.
  assign w_match = (r_state == ST_RUN) && din_valid && !cfg_load &&
                   (w_fill_next >= r_len) &&
                   ((w_hist_next & w_mask) == (r_pattern & w_mask));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_hist    <= '0;
      r_fill    <= '0;
      r_pattern <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      r_dout    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_armed   <= 1'b0;
    end else if (cfg_load) begin
      r_dout <= 1'b0;
      if (w_cfg_ok) begin
        r_pattern <= cfg_pattern;
        r_len     <= cfg_len;
        r_overlap <= cfg_overlap;
        r_hist    <= '0;
        r_fill    <= '0;
        r_cfg_err <= 1'b0;
        r_state   <= ST_RUN;
        r_armed   <= 1'b1;
      end else begin
        r_cfg_err <= 1'b1;
        r_state   <= ST_IDLE;
        r_armed   <= 1'b0;
      end
    end else if ((r_state == ST_RUN) && din_valid) begin
      r_hist <= w_hist_next;
      // Non-overlapping mode forgets every bit that took part in a match.
      r_fill <= (w_match && !r_overlap) ? '0 : w_fill_next;
      r_dout <= w_match;
    end else begin
      r_dout <= 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_match),
    .clr   (clr_count),
    .q     (match_count)
  );

  assign dout    = r_dout;
  assign cfg_err = r_cfg_err;
  assign armed   = r_armed;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench: two detector instances (16-bit and 4-bit counters) share stimulus.
module tb_seq_detector_prog;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       din_valid;
  logic       din;
  logic       clr_count;

  logic        dout_a, dout_b;
  logic [15:0] mc_a;
  logic [3:0]  mc_b;
  logic        err_a, err_b;
  logic        armed_a, armed_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_detector_prog #(.MAX_LEN(8), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_valid(din_valid), .din(din),
    .clr_count(clr_count), .dout(dout_a), .match_count(mc_a), .cfg_err(err_a),
    .armed(armed_a)
  );

  seq_detector_prog #(.MAX_LEN(8), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_valid(din_valid), .din(din),
    .clr_count(clr_count), .dout(dout_b), .match_count(mc_b), .cfg_err(err_b),
    .armed(armed_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stream input; dout checked just after the sampling edge.
  task automatic cyc(input logic v, input logic d, input logic clr, input logic exp_d,
                     input string tag);
    @(negedge clk);
    cfg_load = 1'b0; din_valid = v; din = d; clr_count = clr;
    @(posedge clk); #1;
    check({tag, ".dout_a"}, {31'd0, dout_a}, {31'd0, exp_d});
    check({tag, ".dout_b"}, {31'd0, dout_b}, {31'd0, exp_d});
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                      input logic v, input logic d, input logic exp_err, input string tag);
    @(negedge clk);
    cfg_load = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
    din_valid = v; din = d; clr_count = 1'b0;
    @(posedge clk); #1;
    check({tag, ".err_a"}, {31'd0, err_a}, {31'd0, exp_err});
    check({tag, ".err_b"}, {31'd0, err_b}, {31'd0, exp_err});
    check({tag, ".armed_a"}, {31'd0, armed_a}, {31'd0, !exp_err});
    check({tag, ".armed_b"}, {31'd0, armed_b}, {31'd0, !exp_err});
    check({tag, ".dout_a"}, {31'd0, dout_a}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    din_valid = 1'b0; din = 1'b0; clr_count = 1'b0;
    #12;
    check("rst.dout", {31'd0, dout_a}, 32'd0);
    check("rst.count", {16'd0, mc_a}, 32'd0);
    check("rst.err", {31'd0, err_a}, 32'd0);
    check("rst.armed", {31'd0, armed_a}, 32'd0);
    @(negedge clk); reset = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, "idle_ignored");

    // Overlapping "1010"
    load(8'b0000_1010, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, "ld_ov1");
    cyc(1, 1, 0, 0, "ov1.b1"); cyc(1, 0, 0, 0, "ov1.b2");
    cyc(1, 1, 0, 0, "ov1.b3"); cyc(1, 0, 0, 1, "ov1.b4");
    cyc(1, 1, 0, 0, "ov1.b5"); cyc(1, 0, 0, 1, "ov1.b6");
    check("ov1.count_a", {16'd0, mc_a}, 32'd2);
    check("ov1.count_b", {28'd0, mc_b}, 32'd2);

    // Non-overlapping "1010"; the load itself must not clear the count
    load(8'b0000_1010, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, "ld_ov0");
    check("ld_keeps_count", {16'd0, mc_a}, 32'd2);
    cyc(0, 0, 1, 0, "clr0");
    check("clr0.count", {16'd0, mc_a}, 32'd0);
    cyc(1, 1, 0, 0, "ov0.b1"); cyc(1, 0, 0, 0, "ov0.b2");
    cyc(1, 1, 0, 0, "ov0.b3"); cyc(1, 0, 0, 1, "ov0.b4");
    cyc(1, 1, 0, 0, "ov0.b5"); cyc(1, 0, 0, 0, "ov0.b6");
    check("ov0.count1", {16'd0, mc_a}, 32'd1);
    cyc(1, 1, 0, 0, "ov0.b7"); cyc(1, 0, 0, 1, "ov0.b8");
    check("ov0.count2", {16'd0, mc_a}, 32'd2);

    // Illegal lengths
    load(8'b0000_0001, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, "ld_len1");
    load(8'b1111_1111, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1, "ld_len9");
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "err_rand");
    check("err.count", {16'd0, mc_a}, 32'd2);
    load(8'b0000_0111, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, "ld_111");

    // "111" with din_valid toggling
    cyc(0, 0, 1, 0, "clr1");
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, 1'b1, 1'b0, (k >= 3), "v111.valid");
      cyc(1'b0, 1'b1, 1'b0, 1'b0, "v111.invalid");
    end
    check("v111.count_a", {16'd0, mc_a}, 32'd6);
    check("v111.count_b", {28'd0, mc_b}, 32'd6);

    // Saturation with "11" and clear-wins-over-match
    load(8'b0000_0011, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, "ld_11");
    cyc(0, 0, 1, 0, "clr2");
    for (int k = 1; k <= 20; k++) cyc(1'b1, 1'b1, 1'b0, (k >= 2), "sat.bit");
    check("sat.count_a", {16'd0, mc_a}, 32'd19);
    check("sat.count_b", {28'd0, mc_b}, 32'd15);
    cyc(1, 1, 1, 1, "clr_vs_match");
    check("clr_vs_match.a", {16'd0, mc_a}, 32'd0);
    check("clr_vs_match.b", {28'd0, mc_b}, 32'd0);

    // Asynchronous reset mid-cycle while dout is high
    load(8'b0000_1010, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, "ld_rst");
    cyc(1, 1, 0, 0, "pre.b1"); cyc(1, 0, 0, 0, "pre.b2");
    cyc(1, 1, 0, 0, "pre.b3"); cyc(1, 0, 0, 1, "pre.b4");
    #2 reset = 1'b1;
    #1;
    check("arst.dout", {31'd0, dout_a}, 32'd0);
    check("arst.count", {16'd0, mc_a}, 32'd0);
    check("arst.armed", {31'd0, armed_a}, 32'd0);
    @(negedge clk); reset = 1'b0;
    cyc(1, 1, 0, 0, "post_rst_idle");
    check("post_rst.armed", {31'd0, armed_a}, 32'd0);
    load(8'b0000_1010, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, "ld_after_rst");
    cyc(1, 0, 0, 0, "ar.b0"); cyc(1, 1, 0, 0, "ar.b1");
    cyc(1, 0, 0, 0, "ar.b2"); cyc(1, 1, 0, 0, "ar.b3");
    cyc(1, 0, 0, 1, "ar.b4");
    cyc(1, 1, 0, 0, "ar.b5");

    // Load coincides with the bit that would complete "1010": bit dropped
    load(8'b0000_1010, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, "ld_with_din");
    check("ld_with_din.count", {16'd0, mc_a}, 32'd1);
    cyc(1, 0, 0, 0, "after_ld.b1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
